microseq_next_ctrl: RTL and testbench
=====================================

// Module: microseq_next_ctrl
// PURPOSE
//  Next-address controller for the microsequencer; sits directly upstream of the microaddress counter.
//  Decodes the current microinstruction's sequencing field and the selected condition flag.
//  Drives the counter's cmd/load_addr inputs.
//  Holds a return-address stack for micro-subroutine CALL/RET and a HALTED state.
// PARAMETERS
//  ADDR_W  11  microaddress width; must equal counter addr width (11)
//  DEPTH   4   return-stack entries (>=1)
//  NCOND   8   number of condition flag inputs (<=8)
// PORTS
//  clk          in   1               clock, all state updates on posedge
//  reset        in   1               synchronous, active-high
//  cur_addr     in   ADDR_W          counter's current addr (microinstruction being executed)
//  seq_op       in   3               sequencing field of current microinstruction
//  target       in   ADDR_W          branch/call target field
//  cond_sel     in   3               index into cond_flags
//  cond_pol     in   1               1 = invert selected flag
//  cond_flags   in   NCOND           datapath status flags
//  stall        in   1               datapath busy; freeze sequencing
//  cmd          out  microaddr::cmd  HOLD/INC/LOAD to counter
//  load_addr    out  ADDR_W          address for LOAD
//  stack_depth  out  $clog2(DEPTH+1) valid stack entries
//  halted       out  1               state == HALTED
//  err          out  1               sticky stack error (see CONFIGURATION)
// BEHAVIOUR
//  - Decode and outputs: cmd and load_addr are combinational from current inputs and state (0 cycles).
//    The counter registers them, so the new addr appears 1 clk later.
//  - load_addr = 0 whenever cmd != LOAD.
//  - cond = cond_flags[cond_sel] ^ cond_pol.
//  - cond_sel >= NCOND reads as flag 0.
//  - States: RUN, HALTED. Reset -> RUN.
//  - HALTED exits only via reset.
//  - Reset (in cycle): cmd=HOLD, load_addr=0, stack_depth=0, halted=0, err=0. Stack cleared.
//  - RUN, stall=1: cmd=HOLD, no stack or state change, whatever seq_op is.
//  - RUN, stall=0, by seq_op:
//    0 SEQ   -> INC
//    1 JUMP  -> LOAD target
//    2 CJMP  -> cond ? LOAD target : INC
//    3 CALL  -> push (cur_addr+1) mod 2^ADDR_W; LOAD target
//    4 RET   -> pop; LOAD popped entry
//    5 WAIT  -> cond ? INC : HOLD (re-evaluated every cycle)
//    6 HALT  -> HOLD; next state HALTED
//    7 rsvd  -> INC
//  - HALTED: cmd=HOLD regardless of inputs. No stack activity.
//  - Stack: LIFO, DEPTH entries. Push/pop take effect at the posedge ending the cycle.
//    At most one stack operation per cycle.
//  - Return address wraps: cur_addr = 2^ADDR_W-1 pushes 0.
//  - CALL at depth == DEPTH (overflow): behaviour set by CONFIGURATION.
//  - RET at depth == 0 (underflow): behaviour set by CONFIGURATION.
//  - Reset asserted mid-WAIT, mid-stall or while HALTED: same as cold reset.
// CONFIGURATION
//  Macro MICROSEQ_STACK_CHECK_EN.
//  - Defined:
//    overflow  -> no push, cmd=HOLD, err<=1, next state HALTED.
//    underflow -> cmd=HOLD, err<=1, next state HALTED.
//    err stays set until reset.
//  - Undefined:
//    overflow  -> overwrite top entry; depth stays DEPTH; cmd=LOAD target.
//    underflow -> cmd=LOAD 0; depth stays 0.
//    err tied to 0.
// TESTING
//  1. Reset, then SEQ x3 from addr 0 -> cmd=INC each cycle; counter addr 0,1,2,3.
//  2. CALL target=0x100 at cur_addr=0x010, then RET at 0x100
//     -> LOAD 0x100, depth 1; then LOAD 0x011, depth 0.
//  3. CJMP target=0x050, cond_sel=2, cond_pol=0:
//     flag2=0 -> INC; flag2=1 -> LOAD 0x050; cond_pol=1 inverts both.
//  4. WAIT with cond=0 for 5 cycles, stall pulse, then cond=1
//     -> HOLD x5 (HOLD during stall), then INC; HALT -> halted=1, HOLD until reset.
//  5. DEPTH=4: 5 CALLs.
//     With macro: 5th gives HOLD, err=1, halted=1.
//     Without: 5th LOADs target, depth=4, 4 RETs return the 5th, 3rd, 2nd, 1st return addresses.
//  6. RET at depth 0 (both macro settings) and CALL at cur_addr=0x7FF (pushes 0x000).
//     Reset during stall clears depth/err/halted.

Source files
------------

// File: rtl/microseq_next_ctrl.sv
// Next-address controller: decodes seq_op/condition into counter cmd, keeps the return stack and RUN/HALTED state.
// Define MICROSEQ_STACK_CHECK_EN to trap stack overflow/underflow into HALTED with a sticky err.
package microaddr;
  typedef enum logic [1:0] {HOLD = 2'd0, INC = 2'd1, LOAD = 2'd2} cmd;
endpackage

module microseq_next_ctrl #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NCOND  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cur_addr,
  input  logic [2:0]                   seq_op,
  input  logic [ADDR_W-1:0]            target,
  input  logic [2:0]                   cond_sel,
  input  logic                         cond_pol,
  input  logic [NCOND-1:0]             cond_flags,
  input  logic                         stall,
  output microaddr::cmd                cmd,
  output logic [ADDR_W-1:0]            load_addr,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         halted,
  output logic                         err
);
  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, HALTED} state_t;
  typedef enum logic [2:0] {
    OP_SEQ, OP_JUMP, OP_CJMP, OP_CALL, OP_RET, OP_WAIT, OP_HALT, OP_RSVD
  } op_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] stack [DEPTH];
  logic [7:0]        flags_ext;
  logic              cond, full, empty, push, pop;
  logic [IW-1:0]     top;
  logic [ADDR_W-1:0] ret_addr;
`ifdef MICROSEQ_STACK_CHECK_EN
  logic              err_set;
`else
  logic              ovw;
`endif

  // Flags are zero-extended to 8 so cond_sel can index without width games.
  assign flags_ext = 8'(cond_flags);
  assign cond      = ((32'(cond_sel) < NCOND) ? flags_ext[cond_sel] : flags_ext[0]) ^ cond_pol;
  assign full      = (stack_depth == DW'(DEPTH));
  assign empty     = (stack_depth == '0);
  assign top       = IW'(stack_depth - 1'b1);
  assign ret_addr  = cur_addr + 1'b1;
  assign halted    = (state == HALTED);

  always_comb begin
    cmd        = microaddr::HOLD;
    load_addr  = '0;
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef MICROSEQ_STACK_CHECK_EN
    err_set    = 1'b0;
`else
    ovw        = 1'b0;
`endif
    if (!reset && state == RUN && !stall) begin
      unique case (op_t'(seq_op))
        OP_SEQ, OP_RSVD: cmd = microaddr::INC;
        OP_JUMP: begin
          cmd       = microaddr::LOAD;
          load_addr = target;
        end
        OP_CJMP: begin
          if (cond) begin
            cmd       = microaddr::LOAD;
            load_addr = target;
          end else begin
            cmd = microaddr::INC;
          end
        end
        OP_CALL: begin
          if (full) begin
`ifdef MICROSEQ_STACK_CHECK_EN
            err_set    = 1'b1;
            state_next = HALTED;
`else
            ovw       = 1'b1;
            cmd       = microaddr::LOAD;
            load_addr = target;
`endif
          end else begin
            push      = 1'b1;
            cmd       = microaddr::LOAD;
            load_addr = target;
          end
        end
        OP_RET: begin
          if (empty) begin
`ifdef MICROSEQ_STACK_CHECK_EN
            err_set    = 1'b1;
            state_next = HALTED;
`else
            cmd = microaddr::LOAD;
`endif
          end else begin
            pop       = 1'b1;
            cmd       = microaddr::LOAD;
            load_addr = stack[top];
          end
        end
        OP_WAIT: if (cond) cmd = microaddr::INC;
        OP_HALT: state_next = HALTED;
        default: cmd = microaddr::HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stack_depth <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      state <= state_next;
      if (push) begin
        stack[IW'(stack_depth)] <= ret_addr;
        stack_depth             <= stack_depth + 1'b1;
      end else if (pop) begin
        stack_depth <= stack_depth - 1'b1;
      end
`ifndef MICROSEQ_STACK_CHECK_EN
      if (ovw) stack[top] <= ret_addr;
`endif
    end
  end

`ifdef MICROSEQ_STACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_microseq_next_ctrl.sv
// Directed + random checks of microseq_next_ctrl against a queue-based behavioural model with a modelled counter.
module tb_microseq_next_ctrl;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NCOND  = 8;
  localparam int          AMOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        seq_op;
  logic [ADDR_W-1:0] target;
  logic [2:0]        cond_sel;
  logic              cond_pol;
  logic [NCOND-1:0]  cond_flags;
  logic              stall;
  microaddr::cmd     cmd;
  logic [ADDR_W-1:0] load_addr;
  logic [2:0]        stack_depth;
  logic              halted;
  logic              err;

  always #5 clk = ~clk;

  microseq_next_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NCOND(NCOND)) dut (
    .clk(clk), .reset(reset), .cur_addr(cur_addr), .seq_op(seq_op), .target(target),
    .cond_sel(cond_sel), .cond_pol(cond_pol), .cond_flags(cond_flags), .stall(stall),
    .cmd(cmd), .load_addr(load_addr), .stack_depth(stack_depth), .halted(halted), .err(err)
  );

  int passed = 0;
  int total  = 0;

  // Behavioural model: return stack as a queue, plus halted/err flags and the counter address.
  int rstack[$];
  bit m_halted, m_err;
  int pc;

  localparam int C_HOLD = 0, C_INC = 1, C_LOAD = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input int op, input int tgt, input int sel, input bit pol,
                      input int flags, input bit stl, input bit rst);
    int  ecmd, eload, ret;
    bit  c, p_clear, p_push, p_pop, p_ovw, p_halt, p_err;
    ecmd = C_HOLD; eload = 0;
    p_clear = 0; p_push = 0; p_pop = 0; p_ovw = 0; p_halt = 0; p_err = 0;
    reset = rst; seq_op = 3'(op); target = ADDR_W'(tgt); cond_sel = 3'(sel);
    cond_pol = pol; cond_flags = NCOND'(flags); stall = stl; cur_addr = ADDR_W'(pc);
    c   = bit'((((sel < NCOND) ? (flags >> sel) : flags) & 1)) ^ pol;
    ret = (pc + 1) % AMOD;
    if (rst) p_clear = 1;
    else if (!m_halted && !stl) begin
      case (op)
        1: begin ecmd = C_LOAD; eload = tgt; end
        2: if (c) begin ecmd = C_LOAD; eload = tgt; end else ecmd = C_INC;
        3: if (rstack.size() == DEPTH) begin
`ifdef MICROSEQ_STACK_CHECK_EN
             p_halt = 1; p_err = 1;
`else
             p_ovw = 1; ecmd = C_LOAD; eload = tgt;
`endif
           end else begin p_push = 1; ecmd = C_LOAD; eload = tgt; end
        4: if (rstack.size() == 0) begin
`ifdef MICROSEQ_STACK_CHECK_EN
             p_halt = 1; p_err = 1;
`else
             ecmd = C_LOAD; eload = 0;
`endif
           end else begin p_pop = 1; ecmd = C_LOAD; eload = rstack[$]; end
        5: ecmd = c ? C_INC : C_HOLD;
        6: p_halt = 1;
        default: ecmd = C_INC;
      endcase
    end
    @(negedge clk);
    chk({tag, ".cmd"},   32'(cmd),         32'(ecmd));
    chk({tag, ".load"},  32'(load_addr),   32'(eload));
    chk({tag, ".depth"}, 32'(stack_depth), 32'(rstack.size()));
    chk({tag, ".halt"},  32'(halted),      32'(m_halted));
    chk({tag, ".err"},   32'(err),         32'(m_err));
    @(posedge clk);
    if (p_clear) begin
      rstack.delete(); m_halted = 0; m_err = 0; pc = 0;
    end else begin
      if (p_push) rstack.push_back(ret);
      if (p_pop)  void'(rstack.pop_back());
      if (p_ovw)  rstack[rstack.size()-1] = ret;
      if (p_halt) m_halted = 1;
      if (p_err)  m_err = 1;
      if (ecmd == C_INC)  pc = (pc + 1) % AMOD;
      if (ecmd == C_LOAD) pc = eload;
    end
    #1;
  endtask

  initial begin
    int op;
    bit rst;
    reset = 1'b1; seq_op = '0; target = '0; cond_sel = '0; cond_pol = 1'b0;
    cond_flags = '0; stall = 1'b0; cur_addr = '0;
    m_halted = 0; m_err = 0; pc = 0;
    @(posedge clk); #1;

    // 1: reset then sequential
    step("t1.rst", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("t1.seq", 0, 0, 0, 0, 0, 0, 0);
    // 2: call/return
    step("t2.jmp",  1, 'h010, 0, 0, 0, 0, 0);
    step("t2.call", 3, 'h100, 0, 0, 0, 0, 0);
    step("t2.ret",  4, 'h3AA, 0, 0, 0, 0, 0);
    step("t2.seq",  0, 0, 0, 0, 0, 0, 0);
    // 3: conditional jump, both polarities
    step("t3.f0p0", 2, 'h050, 2, 0, 'h00, 0, 0);
    step("t3.f1p0", 2, 'h050, 2, 0, 'h04, 0, 0);
    step("t3.f0p1", 2, 'h050, 2, 1, 'hFB, 0, 0);
    step("t3.f1p1", 2, 'h050, 2, 1, 'h04, 0, 0);
    step("t3.s7",   2, 'h070, 7, 0, 'h80, 0, 0);
    // 4: wait, stall, halt
    for (int i = 0; i < 5; i++) step("t4.wait0", 5, 0, 1, 0, 'h00, 0, 0);
    step("t4.stall", 5, 0, 1, 0, 'h02, 1, 0);
    step("t4.wait1", 5, 0, 1, 0, 'h02, 0, 0);
    step("t4.halt",  6, 0, 0, 0, 0, 0, 0);
    step("t4.h_seq", 0, 0, 0, 0, 0, 0, 0);
    step("t4.h_jmp", 1, 'h123, 0, 0, 0, 0, 0);
    step("t4.h_cal", 3, 'h123, 0, 0, 0, 0, 0);
    step("t4.rst",   0, 0, 0, 0, 0, 0, 1);
    // 5: five calls into a 4-deep stack
    for (int i = 0; i < 5; i++) step("t5.call", 3, 'h200 + 'h100 * i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t5.ret", 4, 0, 0, 0, 0, 0, 0);
    step("t5.post", 0, 0, 0, 0, 0, 0, 0);
    // 6: underflow, return-address wrap, reset during stall/halt
    step("t6.rst",   0, 0, 0, 0, 0, 0, 1);
    step("t6.uflow", 4, 'h055, 0, 0, 0, 0, 0);
    step("t6.after", 0, 0, 0, 0, 0, 0, 0);
    step("t6.rst2",  0, 0, 0, 0, 0, 0, 1);
    step("t6.jmp",   1, 'h7FF, 0, 0, 0, 0, 0);
    step("t6.call",  3, 'h123, 0, 0, 0, 0, 0);
    step("t6.ret",   4, 0, 0, 0, 0, 0, 0);
    step("t6.call2", 3, 'h321, 0, 0, 0, 0, 0);
    step("t6.stall", 3, 'h321, 0, 0, 0, 1, 0);
    step("t6.rstst", 3, 'h321, 0, 0, 0, 1, 1);
    step("t6.chk",   0, 0, 0, 0, 0, 0, 0);
    step("t6.halt",  6, 0, 0, 0, 0, 0, 0);
    step("t6.rsthl", 0, 0, 0, 0, 0, 0, 1);
    step("t6.chk2",  0, 0, 0, 0, 0, 0, 0);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 7);
      if (op == 6 && $urandom_range(0, 1) == 0) op = $urandom_range(0, 5);
      rst = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      step("rnd", op, $urandom_range(0, AMOD - 1), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 255), $urandom_range(0, 4) == 0, rst);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
